// File: rtl/cache_mem_responder_if.sv
// Cache-to-memory miss/write-through bus between dcache (master) and responder (slave).
// Latency: n/a (wires only).
// Backpressure: none on the bus itself; writes seen while full are dropped by the slave.
interface cache_mem_responder_if;
    logic        cache_req_i;
    logic [31:0] cache_addr_i;
    logic        cache_write_i;
    logic [31:0] cache_write_data_i;
    logic [3:0]  cache_write_mask_i;
    logic        cache_rep_o;
    logic [63:0] cache_rep_data_o;
    logic        busy_o;
    logic        wbuf_full_o;
    logic        wr_drop_o;

    modport master (
        output cache_req_i, cache_addr_i, cache_write_i, cache_write_data_i, cache_write_mask_i,
        input  cache_rep_o, cache_rep_data_o, busy_o, wbuf_full_o, wr_drop_o
    );

    modport slave (
        input  cache_req_i, cache_addr_i, cache_write_i, cache_write_data_i, cache_write_mask_i,
        output cache_rep_o, cache_rep_data_o, busy_o, wbuf_full_o, wr_drop_o
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder: buffers masked word writes, answers block reads from a byte RAM.
// Latency: read response LATENCY cycles after acceptance; each buffered write drains first.
// Backpressure: reads wait for an idle FSM and empty buffer; writes arriving while full are dropped (sticky flag).
module cache_mem_responder #(
    parameter int MEM_ADDR_BIT   = 12,
    parameter int LATENCY        = 4,
    parameter int WBUF_DEPTH_BIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_mem_responder_if.slave  bus
);
    localparam int PW        = WBUF_DEPTH_BIT + 1;
    localparam int DEPTH     = 1 << WBUF_DEPTH_BIT;
    localparam int MEM_BYTES = 1 << MEM_ADDR_BIT;

    typedef enum logic [1:0] {IDLE, DRAIN, RD_WAIT, RESP} state_t;

    // Word address only: the two byte-offset bits never matter for a word write.
    typedef struct packed {
        logic [MEM_ADDR_BIT-3:0] word;
        logic [31:0]             data;
        logic [3:0]              mask;
    } wbuf_ent_t;

    state_t                  state;
    logic [PW-1:0]           wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [3:0]              cnt;
    logic                    req_armed;
    logic [MEM_ADDR_BIT-4:0] rd_blk;
    wbuf_ent_t               wbuf [DEPTH];
    wbuf_ent_t               head;
    logic [7:0]              mem [MEM_BYTES];

    logic                    wb_empty, wb_full, wb_empty_n, wb_full_n;
    logic                    enq, deq, rd_accept;

    logic                    rep_q, busy_q, full_q, drop_q;
    logic [63:0]             rep_data_q;

    assign head                 = wbuf[rd_ptr[PW-2:0]];
    assign bus.cache_rep_o      = rep_q;
    assign bus.cache_rep_data_o = rep_data_q;
    assign bus.busy_o           = busy_q;
    assign bus.wbuf_full_o      = full_q;
    assign bus.wr_drop_o        = drop_q;

    // Buffer occupancy, handshakes and next-pointer values shared by storage and FSM.
    always_comb begin
        wb_empty   = (wr_ptr == rd_ptr);
        wb_full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
        enq        = bus.cache_write_i && !wb_full;
        deq        = (state == DRAIN) && !wb_empty;
        wr_ptr_n   = wr_ptr + PW'(enq);
        rd_ptr_n   = rd_ptr + PW'(deq);
        wb_empty_n = (wr_ptr_n == rd_ptr_n);
        wb_full_n  = (wr_ptr_n[PW-1] != rd_ptr_n[PW-1]) && (wr_ptr_n[PW-2:0] == rd_ptr_n[PW-2:0]);
        // A write landing in the same cycle must be drained before the read it accompanies.
        rd_accept  = (state == IDLE) && wb_empty && !bus.cache_write_i
                     && bus.cache_req_i && req_armed;
    end

    // Buffer storage and RAM commit; neither is reset, a reset edge just suppresses the commit.
    always_ff @(posedge clk) begin
        if (enq) begin
            wbuf[wr_ptr[PW-2:0]] <= '{word: bus.cache_addr_i[MEM_ADDR_BIT-1:2],
                                      data: bus.cache_write_data_i,
                                      mask: bus.cache_write_mask_i};
        end
        if (rst && deq) begin
            for (int j = 0; j < 4; j++) begin
                if (head.mask[3-j]) begin
                    mem[{head.word, 2'(j)}] <= head.data[8*(3-j) +: 8];
                end
            end
        end
    end

    // Control FSM with buffer pointers and all registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            req_armed  <= 1'b1;
            rd_blk     <= '0;
            rep_q      <= 1'b0;
            rep_data_q <= '0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            full_q <= wb_full_n;
            rep_q  <= 1'b0;
            if (bus.cache_write_i && wb_full) begin
                drop_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!wb_empty) begin
                        state  <= DRAIN;
                        busy_q <= 1'b1;
                    end else if (rd_accept) begin
                        rd_blk <= bus.cache_addr_i[MEM_ADDR_BIT-1:3];
                        cnt    <= 4'(LATENCY - 1);
                        state  <= RD_WAIT;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= !wb_empty_n;
                    end
                end
                DRAIN: begin
                    if (wb_empty_n) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    busy_q <= 1'b1;
                    if (cnt == 4'd0) begin
                        for (int k = 0; k < 8; k++) begin
                            rep_data_q[8*k +: 8] <= mem[{rd_blk, 3'(k)}];
                        end
                        rep_q     <= 1'b1;
                        req_armed <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= !wb_empty_n;
                end
            endcase
            // A low request cycle re-arms; placed last so it wins over the response clear.
            if (!bus.cache_req_i) begin
                req_armed <= 1'b1;
            end
        end
    end
endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Memory-side responder for the data-cache miss/write-through interface. It accepts block-read requests and masked word writes from `dcache`. Writes are absorbed into a small in-order write buffer. Read misses are answered with a 64-bit block after a fixed access latency, and every read observes all writes accepted before or with it. It sits between the cache and a behavioural byte-addressed RAM, which the block contains.

## Interface
Parameters:
- `MEM_ADDR_BIT`, default 12: RAM is 2^MEM_ADDR_BIT bytes. Higher address bits are ignored, so addresses wrap.
- `LATENCY`, default 4: cycles from read acceptance to response. Legal range is 1..15.
- `WBUF_DEPTH_BIT`, default 2: the write buffer holds 2^WBUF_DEPTH_BIT entries.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `cache_req_i`  in  1  level read request; held by the cache until served.
- `cache_addr_i`  in  32  byte address for read or write.
- `cache_write_i`  in  1  write strobe; one write per high cycle.
- `cache_write_data_i`  in  32  write word.
- `cache_write_mask_i`  in  4  byte enables for the write word.
- `cache_rep_o`  out  1  one-cycle response pulse for a read.
- `cache_rep_data_o`  out  64  response block; holds its value until the next response.
- `busy_o`  out  1  high in any non-IDLE state or when the buffer is non-empty.
- `wbuf_full_o`  out  1  write buffer is full.
- `wr_drop_o`  out  1  sticky flag; set when a write arrives while the buffer is full.

## Operation
- Block addressing:
  - blk = addr & ~7.
  - Read response byte k (k = 0..7) is RAM[blk+k], placed in `cache_rep_data_o[8k+7:8k]`.
- Write byte lanes (big-endian within the word):
  - w = addr & ~3.
  - mask[3] writes data[31:24] to RAM[w+0].
  - mask[2] writes data[23:16] to RAM[w+1].
  - mask[1] writes data[15:8] to RAM[w+2].
  - mask[0] writes data[7:0] to RAM[w+3].
  - A mask of 0 is enqueued and commits nothing.
- Write buffer:
  - FIFO of {addr, data, mask}.
  - Enqueue occurs on any cycle where `cache_write_i`=1 and the buffer is not full.
  - If `cache_write_i`=1 while full, the write is dropped and `wr_drop_o` is set. `wr_drop_o` clears only on reset.
  - Head and tail pointers are WBUF_DEPTH_BIT+1 bits wide and wrap; full/empty are decided by the MSB compare.
  - An enqueue and a dequeue in the same cycle are both performed, and the count is unchanged.
- Read acceptance:
  - A read is accepted on an edge where the state is IDLE, the buffer is empty, `cache_req_i`=1 and `req_armed`=1.
  - The address is latched into `rd_addr` at acceptance.
  - `req_armed` is cleared at the response. It is set again by any cycle with `cache_req_i`=0, so a held request is never served twice.
- State machine:
  - IDLE:
    - if the buffer is non-empty, go to DRAIN;
    - else if a read is acceptable, latch the address, load cnt=LATENCY-1 and go to RD_WAIT.
  - DRAIN: commit the head entry to RAM and dequeue, one entry per cycle. Go to IDLE when the last entry is committed.
  - RD_WAIT: if cnt=0, capture the RAM block into `cache_rep_data_o`, assert `cache_rep_o` and go to RESP; else decrement cnt.
  - RESP: deassert `cache_rep_o` and go to IDLE.
- Ordering:
  - A write enqueued in the same cycle as a pending read is drained before that read is accepted.
  - Writes arriving during RD_WAIT are enqueued. Their RAM commit waits until after RESP, so they are not visible in that response.
- Reset (rst=0 at an edge, including mid-read or mid-drain):
  - state returns to IDLE and the buffer is emptied, discarding pending writes;
  - `req_armed`=1 and cnt=0;
  - RAM contents are not reset.

## Timing
- Reset values:
  - `cache_rep_o`=0, `cache_rep_data_o`=0, `busy_o`=0;
  - `wbuf_full_o`=0, `wr_drop_o`=0.
- Read latency, for a read accepted at edge E0 from IDLE with an empty buffer:
  - `cache_rep_o` is high for exactly the one cycle following edge E0+LATENCY.
  - The earliest next acceptance is edge E0+LATENCY+2, and only if the request was low for at least one cycle.
- Each buffered write adds one cycle (its DRAIN slot) ahead of a waiting read.
- `wbuf_full_o` and `busy_o` are registered and reflect state after each edge.
- A write that sees `wbuf_full_o`=1 in the same cycle is dropped.

## Test plan
- Reset then read:
  - Stimulus: preload RAM[0x100..0x107] with 0x11..0x88; hold `cache_req_i`=1 with addr 0x104.
  - Required: a single `cache_rep_o` pulse LATENCY+1 cycles after acceptance, with data 0x8877665544332211. No second pulse while req stays high.
- Write then read-back:
  - Stimulus: write addr 0x200, data 0xAABBCCDD, mask 0xF; in the same cycle request a read of 0x200.
  - Required: 1 drain cycle, then a response with data[31:0]=0xDDCCBBAA (RAM[0x200]=0xAA).
- Partial mask:
  - Stimulus: RAM[0x300..0x303]=0; write data 0x12345678, mask 0b0101.
  - Required: RAM[0x301]=0x34, RAM[0x303]=0x78, RAM[0x300]=RAM[0x302]=0.
- Buffer full:
  - Stimulus: while a read is in RD_WAIT, issue 5 consecutive writes (depth 4).
  - Required: `wbuf_full_o`=1 after the 4th write; the 5th write is dropped; `wr_drop_o`=1; the 4 accepted writes commit in order after RESP.
- Address wrap:
  - Stimulus: read addr 0x00001008 with MEM_ADDR_BIT=12.
  - Required: the response equals a read of addr 0x008.
- Reset mid-read:
  - Stimulus: assert rst=0 during RD_WAIT with 2 writes still buffered.
  - Required: no `cache_rep_o` pulse; `busy_o`=0 and `wbuf_full_o`=0 the next cycle; the discarded writes do not appear in RAM.
